// File: rtl/layer_sequencer.sv
// layer_sequencer: streams one dense layer's weights/inputs through a MAC,
// adds bias, optional ReLU, saturates to 32 bits and emits one result per neuron.
module layer_sequencer #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  localparam int WAW = ($clog2(N_IN*N_OUT) > 1) ? $clog2(N_IN*N_OUT) : 1,
  localparam int XAW = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1,
  localparam int BAW = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic                relu_en,
  output logic                rd_en,
  output logic [WAW-1:0]      w_addr,
  output logic [XAW-1:0]      x_addr,
  input  logic signed [15:0]  w_data,
  input  logic signed [15:0]  x_data,
  output logic                b_rd_en,
  output logic [BAW-1:0]      b_addr,
  input  logic signed [15:0]  b_data,
  output logic                out_valid,
  output logic [BAW-1:0]      out_idx,
  output logic signed [31:0]  out_data,
  output logic                busy,
  output logic                done
);

  localparam int KW  = $clog2(N_IN + 1);
  localparam int ACW = 32 + $clog2(N_IN) + 1;
  localparam logic [KW-1:0]  K_LAST = KW'(N_IN);
  localparam logic [BAW-1:0] N_LAST = BAW'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [BAW-1:0] n_q, n_d;
  logic [KW-1:0]  k_q, k_d;
  logic [ACW-1:0] acc_q, acc_d;
  logic           relu_q, relu_d;
  logic           rdv_q;
  logic           ov_q, ov_d;
  logic           done_q, done_d;
  logic [31:0]    od_q, od_d;
  logic [BAW-1:0] oi_q, oi_d;

  logic signed [31:0] prod;
  logic [ACW:0]       sum;
  logic [ACW-31:0]    hi;
  logic [31:0]        sat;

  assign prod = w_data * x_data;

  // bias add, optional ReLU, then clamp to the signed 32-bit range
  always_comb begin
    sum = {acc_q[ACW-1], acc_q}
        + {{(ACW + 1 - 16){b_data[15]}}, b_data};
    if (relu_q && sum[ACW]) begin
      sum = '0;
    end
    hi = sum[ACW:31];
    if ((&hi) || (~|hi)) begin
      sat = sum[31:0];
    end else if (sum[ACW]) begin
      sat = 32'h8000_0000;
    end else begin
      sat = 32'h7FFF_FFFF;
    end
  end

  // next-state, SRAM strobes/addresses and result capture
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    acc_d   = acc_q;
    relu_d  = relu_q;
    ov_d    = 1'b0;
    done_d  = 1'b0;
    od_d    = od_q;
    oi_d    = oi_q;
    rd_en   = 1'b0;
    b_rd_en = 1'b0;
    w_addr  = '0;
    x_addr  = '0;
    b_addr  = '0;
    unique case (state_q)
      IDLE: begin
        if (!abort && start) begin
          state_d = RUN;
          n_d     = '0;
          k_d     = '0;
          relu_d  = relu_en;
        end
      end
      RUN: begin
        if (k_q < K_LAST) begin
          rd_en  = 1'b1;
          w_addr = WAW'(int'(n_q) * N_IN + int'(k_q));
          x_addr = XAW'(k_q);
        end else begin
          b_rd_en = 1'b1;
          b_addr  = n_q;
        end
        if (k_q == '0) begin
          acc_d = '0;
        end else if (rdv_q) begin
          acc_d = acc_q + {{(ACW - 32){prod[31]}}, prod};
        end
        if (abort) begin
          state_d = IDLE;
        end else if (k_q == K_LAST) begin
          state_d = WB;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      WB: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ov_d = 1'b1;
          od_d = sat;
          oi_d = n_q;
          if (n_q == N_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            n_d     = n_q + BAW'(1);
            k_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      relu_q  <= 1'b0;
      rdv_q   <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      od_q    <= '0;
      oi_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      relu_q  <= relu_d;
      rdv_q   <= rd_en;
      ov_q    <= ov_d;
      done_q  <= done_d;
      od_q    <= od_d;
      oi_q    <= oi_d;
    end
  end

  assign out_valid = ov_q;
  assign done      = done_q;
  assign out_data  = od_q;
  assign out_idx   = oi_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scenarios against a 1-cycle-latency SRAM model.
// Expected results are hand-computed for the default 8x4 geometry.
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic relu_en = 1'b0;
  logic rd_en, b_rd_en;
  logic [4:0] w_addr;
  logic [2:0] x_addr;
  logic [1:0] b_addr;
  logic signed [15:0] w_data = '0;
  logic signed [15:0] x_data = '0;
  logic signed [15:0] b_data = '0;
  logic out_valid;
  logic [1:0] out_idx;
  logic signed [31:0] out_data;
  logic busy, done;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] wmem [32];
  logic signed [15:0] xmem [8];
  logic signed [15:0] bmem [4];
  logic signed [31:0] exp_d [4];

  layer_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .relu_en(relu_en), .rd_en(rd_en), .w_addr(w_addr),
    .x_addr(x_addr), .w_data(w_data), .x_data(x_data),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= wmem[w_addr];
      x_data <= xmem[x_addr];
    end
    if (b_rd_en) begin
      b_data <= bmem[b_addr];
    end
  end

  task automatic load_ones();
    for (int a = 0; a < 32; a++) wmem[a] = 16'sd1;
    for (int k = 0; k < 8; k++) xmem[k] = 16'(k + 1);
    for (int n = 0; n < 4; n++) bmem[n] = 16'sd0;
    for (int n = 0; n < 4; n++) exp_d[n] = 32'sd36;
  endtask

  task automatic run_pass(input logic relu, input string tag);
    int nv;
    nv = 0;
    start = 1'b1;
    relu_en = relu;
    @(posedge clk);
    #1;
    start = 1'b0;
    relu_en = ~relu;
    for (int c = 0; c <= 40; c++) begin
      int n = c / 10;
      int p = c % 10;
      logic e_rd, e_brd, e_ov;
      logic [4:0] e_wa;
      logic [2:0] e_xa;
      logic [1:0] e_ba;
      @(negedge clk);
      e_rd  = (c < 40) && (p < 8);
      e_brd = (c < 40) && (p == 8);
      e_ov  = (c >= 10) && (p == 0);
      e_wa  = e_rd ? 5'(n * 8 + p) : 5'd0;
      e_xa  = e_rd ? 3'(p) : 3'd0;
      e_ba  = e_brd ? 2'(n) : 2'd0;
      checks++;
      if (rd_en !== e_rd) begin
        errors++;
        $display("FAIL %s rd_en c=%0d got %b want %b", tag, c, rd_en, e_rd);
      end
      checks++;
      if (b_rd_en !== e_brd) begin
        errors++;
        $display("FAIL %s b_rd_en c=%0d got %b want %b", tag, c, b_rd_en, e_brd);
      end
      checks++;
      if (w_addr !== e_wa) begin
        errors++;
        $display("FAIL %s w_addr c=%0d got %0d want %0d", tag, c, w_addr, e_wa);
      end
      checks++;
      if (x_addr !== e_xa) begin
        errors++;
        $display("FAIL %s x_addr c=%0d got %0d want %0d", tag, c, x_addr, e_xa);
      end
      checks++;
      if (b_addr !== e_ba) begin
        errors++;
        $display("FAIL %s b_addr c=%0d got %0d want %0d", tag, c, b_addr, e_ba);
      end
      checks++;
      if (busy !== (c < 40)) begin
        errors++;
        $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy, c < 40);
      end
      checks++;
      if (out_valid !== e_ov) begin
        errors++;
        $display("FAIL %s out_valid c=%0d got %b want %b", tag, c, out_valid, e_ov);
      end
      checks++;
      if (done !== (c == 40)) begin
        errors++;
        $display("FAIL %s done c=%0d got %b want %b", tag, c, done, c == 40);
      end
      if (e_ov && out_valid === 1'b1) begin
        nv++;
        checks++;
        if (out_idx !== 2'(n - 1)) begin
          errors++;
          $display("FAIL %s out_idx c=%0d got %0d want %0d", tag, c, out_idx, n - 1);
        end
        checks++;
        if (out_data !== exp_d[n-1]) begin
          errors++;
          $display("FAIL %s out_data idx=%0d got %0d want %0d", tag, n - 1, out_data, exp_d[n-1]);
        end
      end
    end
    checks++;
    if (nv != 4) begin
      errors++;
      $display("FAIL %s result_count got %0d want 4", tag, nv);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, out_valid, rd_en, b_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset strobes got %b want 00000", {busy, done, out_valid, rd_en, b_rd_en});
    end
    checks++;
    if ({out_data, out_idx, w_addr, x_addr, b_addr} !== '0) begin
      errors++;
      $display("FAIL reset values got %h want 0", {out_data, out_idx, w_addr, x_addr, b_addr});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_ones();
    load_ones();
    run_pass(1'b0, "ones");
  endtask

  task automatic test_relu();
    for (int a = 0; a < 32; a++) wmem[a] = -16'sd1;
    for (int k = 0; k < 8; k++) xmem[k] = 16'(k + 1);
    for (int n = 0; n < 4; n++) bmem[n] = 16'(n);
    for (int n = 0; n < 4; n++) exp_d[n] = 32'sd0;
    run_pass(1'b1, "relu_on");
    for (int n = 0; n < 4; n++) exp_d[n] = 32'(-36 + n);
    run_pass(1'b0, "relu_off");
  endtask

  task automatic test_saturation();
    for (int a = 0; a < 32; a++) wmem[a] = -16'sd32768;
    for (int k = 0; k < 8; k++) xmem[k] = -16'sd32768;
    for (int n = 0; n < 4; n++) bmem[n] = 16'sd32767;
    for (int n = 0; n < 4; n++) exp_d[n] = 32'h7FFF_FFFF;
    run_pass(1'b0, "sat_pos");
    for (int k = 0; k < 8; k++) xmem[k] = 16'sd32767;
    for (int n = 0; n < 4; n++) bmem[n] = -16'sd32768;
    for (int n = 0; n < 4; n++) exp_d[n] = 32'h8000_0000;
    run_pass(1'b0, "sat_neg");
  endtask

  task automatic test_addr_sweep();
    for (int a = 0; a < 32; a++) wmem[a] = 16'(a);
    for (int k = 0; k < 8; k++) xmem[k] = 16'sd1;
    for (int n = 0; n < 4; n++) bmem[n] = 16'sd0;
    exp_d[0] = 32'sd28;
    exp_d[1] = 32'sd92;
    exp_d[2] = 32'sd156;
    exp_d[3] = 32'sd220;
    run_pass(1'b0, "addr_sweep");
  endtask

  task automatic test_back_to_back();
    load_ones();
    run_pass(1'b0, "b2b_first");
    run_pass(1'b0, "b2b_second");
  endtask

  task automatic test_abort();
    load_ones();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 10)) begin
        errors++;
        $display("FAIL abort out_valid c=%0d got %b want %b", c, out_valid, c == 10);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL abort done c=%0d got %b want 0", c, done);
      end
      checks++;
      if (busy !== (c < 16)) begin
        errors++;
        $display("FAIL abort busy c=%0d got %b want %b", c, busy, c < 16);
      end
      if (c >= 16) begin
        checks++;
        if ({rd_en, b_rd_en} !== 2'b00) begin
          errors++;
          $display("FAIL abort strobes c=%0d got %b want 00", c, {rd_en, b_rd_en});
        end
      end
      if (c == 10 || c == 30) begin
        checks++;
        if (out_data !== 32'sd36 || out_idx !== 2'd0) begin
          errors++;
          $display("FAIL abort result c=%0d got %0d/%0d want 36/0", c, out_data, out_idx);
        end
      end
      start = (c == 5);
      abort = (c == 15);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_prio busy got %b want 0", busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, out_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_abort got %b want 000", {busy, out_valid, done});
    end
    run_pass(1'b0, "after_abort");
  endtask

  task automatic test_async_reset();
    load_ones();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid, rd_en, b_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset strobes got %b want 00000", {busy, done, out_valid, rd_en, b_rd_en});
    end
    checks++;
    if ({out_data, out_idx, w_addr, x_addr, b_addr} !== '0) begin
      errors++;
      $display("FAIL async_reset values got %h want 0", {out_data, out_idx, w_addr, x_addr, b_addr});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_pass(1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ones();
    test_relu();
    test_saturation();
    test_addr_sweep();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
